// File: rtl/bist_pkg.sv
// Shared definitions for the multi-chain BIST sequencer: state encodings and
// the counter-width helper used to size the shift and capture counters.
package bist_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RST   = 3'd1;
    localparam logic [2:0] ST_GEN   = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_CAP   = 3'd4;
    localparam logic [2:0] ST_SIG   = 3'd5;
    localparam logic [2:0] ST_CMP   = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_RST   = ST_RST,
        S_GEN   = ST_GEN,
        S_SHIFT = ST_SHIFT,
        S_CAP   = ST_CAP,
        S_SIG   = ST_SIG,
        S_CMP   = ST_CMP,
        S_DONE  = ST_DONE
    } state_e;

    // Bits needed to count from 0 up to and including n (never less than 1).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bist_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count flag that
// is high while the count equals last_i. Saturates at all-ones.
module bist_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] last_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins over enable; hold once the counter is saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {WIDTH{1'b0}};
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/bist_multichain_seq.sv
// Multi-chain BIST sequencer: runs a programmable number of
// GEN/SHIFT/CAPTURE/SIG rounds over the enabled scan chains, then compares
// the MISR signature against a golden value. Outputs are Moore-decoded
// from the registered state and the chain mask sampled at start.
module bist_multichain_seq
    import bist_pkg::*;
#(
    parameter int SHIFT_SIZE     = 8,
    parameter int CAPTURE_CYCLES = 1,
    parameter int NUM_CHAINS     = 4,
    parameter int ROUND_W        = 16,
    parameter int SIG_W          = 16
) (
    input  logic                  clk,
    input  logic                  rstIn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ROUND_W-1:0]    num_rounds,
    input  logic [NUM_CHAINS-1:0] chain_en,
    input  logic [SIG_W-1:0]      misr_sig,
    input  logic [SIG_W-1:0]      golden_sig,
    output logic                  NbarT,
    output logic                  rstOut,
    output logic                  PRPG_En,
    output logic [NUM_CHAINS-1:0] SRSG_En,
    output logic [NUM_CHAINS-1:0] SISA_En,
    output logic                  MISR_En,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ROUND_W-1:0]    round_cnt
);

    localparam int SHIFT_W = cnt_width(SHIFT_SIZE);
    localparam int CAP_W   = cnt_width(CAPTURE_CYCLES);
    localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(SHIFT_SIZE - 1);
    localparam logic [CAP_W-1:0]   CAP_LAST   = CAP_W'(CAPTURE_CYCLES - 1);
    localparam logic [ROUND_W-1:0] ROUND_ONE  = ROUND_W'(1);

    state_e                state_q, state_d;
    logic [ROUND_W-1:0]    rounds_q, rounds_d;
    logic [NUM_CHAINS-1:0] mask_q, mask_d;
    logic                  pass_q, pass_d;

    logic sh_clr_s, sh_en_s, sh_tc_s;
    logic cap_clr_s, cap_en_s, cap_tc_s;
    logic rnd_clr_s, rnd_en_s, rnd_tc_s;
    logic [SHIFT_W-1:0] sh_cnt_unused_s;
    logic [CAP_W-1:0]   cap_cnt_unused_s;
    logic [ROUND_W-1:0] rnd_cnt_s;
    logic [ROUND_W-1:0] rnd_last_s;

    // The round counter's terminal value is the last round index of this run.
    assign rnd_last_s = rounds_q - ROUND_ONE;

    bist_counter #(.WIDTH(SHIFT_W)) u_shift_cnt (
        .clk_i (clk),
        .rst_i (rstIn),
        .clr_i (sh_clr_s),
        .en_i  (sh_en_s),
        .last_i(SHIFT_LAST),
        .cnt_o (sh_cnt_unused_s),
        .tc_o  (sh_tc_s)
    );

    bist_counter #(.WIDTH(CAP_W)) u_cap_cnt (
        .clk_i (clk),
        .rst_i (rstIn),
        .clr_i (cap_clr_s),
        .en_i  (cap_en_s),
        .last_i(CAP_LAST),
        .cnt_o (cap_cnt_unused_s),
        .tc_o  (cap_tc_s)
    );

    bist_counter #(.WIDTH(ROUND_W)) u_round_cnt (
        .clk_i (clk),
        .rst_i (rstIn),
        .clr_i (rnd_clr_s),
        .en_i  (rnd_en_s),
        .last_i(rnd_last_s),
        .cnt_o (rnd_cnt_s),
        .tc_o  (rnd_tc_s)
    );

    // State, sampled run configuration and compare result registers.
    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            state_q  <= S_IDLE;
            rounds_q <= {ROUND_W{1'b0}};
            mask_q   <= {NUM_CHAINS{1'b0}};
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rounds_q <= rounds_d;
            mask_q   <= mask_d;
            pass_q   <= pass_d;
        end
    end

    // Next-state logic and counter control; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        rounds_d  = rounds_q;
        mask_d    = mask_q;
        pass_d    = pass_q;
        sh_clr_s  = 1'b0;
        sh_en_s   = 1'b0;
        cap_clr_s = 1'b0;
        cap_en_s  = 1'b0;
        rnd_clr_s = 1'b0;
        rnd_en_s  = 1'b0;
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pass_d = 1'b0;
                        if (chain_en == {NUM_CHAINS{1'b0}}) begin
                            state_d = S_DONE;
                        end else begin
                            rounds_d = (num_rounds == {ROUND_W{1'b0}}) ? ROUND_ONE : num_rounds;
                            mask_d   = chain_en;
                            state_d  = S_RST;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_RST: begin
                    sh_clr_s  = 1'b1;
                    cap_clr_s = 1'b1;
                    rnd_clr_s = 1'b1;
                    state_d   = S_GEN;
                end
                S_GEN: begin
                    sh_clr_s  = 1'b1;
                    cap_clr_s = 1'b1;
                    state_d   = S_SHIFT;
                end
                S_SHIFT: begin
                    sh_en_s = 1'b1;
                    if (sh_tc_s) begin
                        state_d = S_CAP;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
                S_CAP: begin
                    cap_en_s = 1'b1;
                    if (cap_tc_s) begin
                        state_d = S_SIG;
                    end else begin
                        state_d = S_CAP;
                    end
                end
                S_SIG: begin
                    rnd_en_s = 1'b1;
                    if (rnd_tc_s) begin
                        state_d = S_CMP;
                    end else begin
                        state_d = S_GEN;
                    end
                end
                S_CMP: begin
                    pass_d  = (misr_sig == golden_sig);
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Moore output decode from the registered state and sampled chain mask.
    always_comb begin
        NbarT   = 1'b0;
        rstOut  = 1'b0;
        PRPG_En = 1'b0;
        SRSG_En = {NUM_CHAINS{1'b0}};
        SISA_En = {NUM_CHAINS{1'b0}};
        MISR_En = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_RST: begin
                rstOut = 1'b1;
                NbarT  = 1'b1;
            end
            S_GEN: begin
                PRPG_En = 1'b1;
            end
            S_SHIFT: begin
                NbarT   = 1'b1;
                SRSG_En = mask_q;
                SISA_En = mask_q;
            end
            S_CAP: begin
                NbarT = 1'b0;
            end
            S_SIG: begin
                MISR_En = 1'b1;
            end
            S_CMP: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign pass      = pass_q;
    assign round_cnt = rnd_cnt_s;

endmodule

// File: tb/tb_bist_multichain_seq.sv
// Scoreboard bench for bist_multichain_seq: stimulus pushes the expected
// outcome of each run (computed from round arithmetic), a negedge monitor
// counts enable pulses and pops/compares whenever a run ends in done or
// falls back to idle after abort.
module tb_bist_multichain_seq;

    localparam int S  = 8;
    localparam int C  = 1;
    localparam int NC = 4;
    localparam int RW = 16;
    localparam int SW = 16;
    localparam int P  = S + C + 2;

    logic          clk = 1'b0;
    logic          rstIn, start, abort;
    logic [RW-1:0] num_rounds;
    logic [NC-1:0] chain_en;
    logic [SW-1:0] misr_sig, golden_sig;
    logic          NbarT, rstOut, PRPG_En, MISR_En, busy, done, pass;
    logic [NC-1:0] SRSG_En, SISA_En;
    logic [RW-1:0] round_cnt;

    bist_multichain_seq #(
        .SHIFT_SIZE(S), .CAPTURE_CYCLES(C), .NUM_CHAINS(NC), .ROUND_W(RW), .SIG_W(SW)
    ) dut (
        .clk(clk), .rstIn(rstIn), .start(start), .abort(abort),
        .num_rounds(num_rounds), .chain_en(chain_en),
        .misr_sig(misr_sig), .golden_sig(golden_sig),
        .NbarT(NbarT), .rstOut(rstOut), .PRPG_En(PRPG_En),
        .SRSG_En(SRSG_En), .SISA_En(SISA_En), .MISR_En(MISR_En),
        .busy(busy), .done(done), .pass(pass), .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_abort;
        int          lat;
        bit          pass;
        int          rc;
        int          prpg;
        int          misr;
        logic [63:0] chain_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   last_rc  = 0;
    bit   in_done  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected outcome of a run from round arithmetic; ab_r/ab_j (1-based) locate an abort.
    function automatic exp_t model(input int r_in, input logic [NC-1:0] mask,
                                   input bit match, input int ab_r, input int ab_j);
        exp_t e;
        int   r;
        r = (r_in == 0) ? 1 : r_in;
        e.chain_cnt = 64'd0;
        if (mask == 0) begin
            e.is_abort = 1'b0; e.lat = 0; e.pass = 1'b0; e.rc = last_rc;
            e.prpg = 0; e.misr = 0;
            in_done = 1'b1;
        end else if (ab_r != 0) begin
            e.is_abort = 1'b1; e.lat = 1 + (ab_r - 1) * P + ab_j + 1; e.pass = 1'b0;
            e.rc = ab_r - 1; e.prpg = ab_r; e.misr = ab_r - 1;
            for (int i = 0; i < NC; i++)
                if (mask[i]) e.chain_cnt[i*16 +: 16] = 16'((ab_r - 1) * S + ab_j);
            last_rc = e.rc;
            in_done = 1'b0;
        end else begin
            e.is_abort = 1'b0; e.lat = 2 + r * P; e.pass = match;
            e.rc = r; e.prpg = r; e.misr = r;
            for (int i = 0; i < NC; i++)
                if (mask[i]) e.chain_cnt[i*16 +: 16] = 16'(r * S);
            last_rc = r;
            in_done = 1'b1;
        end
        return e;
    endfunction

    // Monitor state
    bit active    = 1'b0;
    bit done_prev = 1'b0;
    int edge_n    = 0;
    int n_prpg    = 0;
    int n_misr    = 0;
    int n_srsg[NC];
    int n_sisa[NC];

    task automatic report(input bit was_abort);
        exp_t        e;
        logic [63:0] cs, ca;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_run_end actual=event required=none");
        end else begin
            e  = exp_q.pop_front();
            cs = 64'd0;
            ca = 64'd0;
            for (int i = 0; i < NC; i++) begin
                cs[i*16 +: 16] = 16'(n_srsg[i]);
                ca[i*16 +: 16] = 16'(n_sisa[i]);
            end
            chk("end_kind_abort", 64'(was_abort), 64'(e.is_abort));
            chk("latency_edges", 64'(edge_n), 64'(e.lat));
            chk("pass", 64'(pass), 64'(e.pass));
            chk("round_cnt", 64'(round_cnt), 64'(e.rc));
            chk("prpg_pulses", 64'(n_prpg), 64'(e.prpg));
            chk("misr_pulses", 64'(n_misr), 64'(e.misr));
            chk("srsg_cycles", cs, e.chain_cnt);
            chk("sisa_cycles", ca, e.chain_cnt);
            if (was_abort)
                chk("abort_outputs_low",
                    64'({NbarT, rstOut, PRPG_En, SRSG_En, SISA_En, MISR_En, done}), 64'd0);
        end
    endtask

    // Monitor: count enables per run; compare when the run reaches done or idle.
    always @(negedge clk) begin
        if (rstIn) begin
            active    = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (active) begin
                edge_n++;
                n_prpg += int'(PRPG_En);
                n_misr += int'(MISR_En);
                for (int i = 0; i < NC; i++) begin
                    n_srsg[i] += int'(SRSG_En[i]);
                    n_sisa[i] += int'(SISA_En[i]);
                end
                if (done && !done_prev) begin
                    report(1'b0);
                    active = 1'b0;
                end else if (!busy && !done) begin
                    report(1'b1);
                    active = 1'b0;
                end
            end
            if (!active && start && !busy) begin
                active = 1'b1;
                edge_n = -1;
                n_prpg = 0;
                n_misr = 0;
                for (int i = 0; i < NC; i++) begin
                    n_srsg[i] = 0;
                    n_sisa[i] = 0;
                end
            end
            done_prev = done;
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("run_reaches_done", 64'(done), 64'd1);
    endtask

    task automatic run(input int r_in, input logic [NC-1:0] mask, input logic [SW-1:0] flip,
                       input int ab_r, input int ab_j, input bit busy_start);
        exp_t          e;
        logic [SW-1:0] sig;
        int            k;
        sig = SW'($urandom);
        e   = model(r_in, mask, (flip == 0), ab_r, ab_j);
        exp_q.push_back(e);
        @(posedge clk); #1;
        num_rounds = RW'(r_in);
        chain_en   = mask;
        misr_sig   = sig;
        golden_sig = sig ^ flip;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        num_rounds = RW'($urandom);
        chain_en   = NC'($urandom);
        if (mask != 0 && ab_r != 0) begin
            k = 1 + (ab_r - 1) * P + ab_j;
            repeat (k) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
        end else begin
            if (busy_start && mask != 0) begin
                repeat (2) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
            wait_done();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            r, ar, aj;
        logic [NC-1:0] m;
        logic [SW-1:0] fl;
        rstIn = 1'b1; start = 1'b0; abort = 1'b0;
        num_rounds = '0; chain_en = '0; misr_sig = '0; golden_sig = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            64'({busy, done, pass, NbarT, rstOut, PRPG_En, SRSG_En, SISA_En, MISR_En}), 64'd0);
        chk("reset_round_cnt", 64'(round_cnt), 64'd0);
        rstIn = 1'b0;

        run(4, 4'b1111, 16'h0000, 0, 0, 1'b0);
        run(4, 4'b1111, 16'h0001, 0, 0, 1'b0);
        run(3, 4'b0101, 16'h0000, 0, 0, 1'b1);
        run(0, 4'b1111, 16'h0000, 0, 0, 1'b0);
        run(4, 4'b1111, 16'h0000, 2, 5, 1'b0);
        run(2, 4'b0000, 16'h0000, 0, 0, 1'b0);
        run(2, 4'b1010, 16'h0000, 0, 0, 1'b1);

        repeat (14) begin
            r  = $urandom_range(0, 5);
            m  = NC'($urandom_range(0, 15));
            if (m == 0 && in_done) m = 4'b0001;
            fl = ($urandom_range(0, 1) == 1) ? SW'(0) : (SW'(1) << $urandom_range(0, SW - 1));
            ar = 0;
            aj = 0;
            if (m != 0 && $urandom_range(0, 3) == 0) begin
                ar = $urandom_range(1, (r == 0) ? 1 : r);
                aj = $urandom_range(1, S);
            end
            run(r, m, fl, ar, aj, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a run returns straight to reset values.
        @(posedge clk); #1;
        num_rounds = 16'd3; chain_en = 4'b1111; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rstIn = 1'b1;
        #1;
        chk("midrun_reset_outputs",
            64'({busy, done, pass, NbarT, rstOut, PRPG_En, SRSG_En, SISA_En, MISR_En}), 64'd0);
        chk("midrun_reset_round_cnt", 64'(round_cnt), 64'd0);
        @(posedge clk); #1;
        rstIn   = 1'b0;
        last_rc = 0;
        in_done = 1'b0;
        run(1, 4'b0011, 16'h0000, 0, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
